// File: rtl/fetch_queue_unit_if.sv
// rtl/fetch_queue_unit_if.sv - instruction memory read port between fetcher and memory
`timescale 1ns/1ps
interface fetch_queue_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] Addr;
    logic                  we;
    logic                  grant;
    logic                  data_valid;
    logic [INST_WIDTH-1:0] rdata;

    modport master (
        output req_valid, Addr, we,
        input  grant, data_valid, rdata
    );

    modport slave (
        input  req_valid, Addr, we,
        output grant, data_valid, rdata
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - pipelined instruction fetcher with PC-tagged prefetch queue
`timescale 1ns/1ps
module fetch_queue_unit #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    INST_WIDTH      = 32,
    parameter int                    MEM_DEPTH       = 16,
    parameter int                    QUEUE_DEPTH     = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_queue_unit_if.master    mem,
    input  logic                  system_stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  system_flush,
    output logic                  uop_valid_out,
    output logic [INST_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  resp_err
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int SW = CW + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         discard;

    logic [ADDR_WIDTH-1:0] inflight [MAX_OUTSTANDING];
    logic [FW-1:0]         if_wr;
    logic [FW-1:0]         if_rd;

    logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0] q_inst [QUEUE_DEPTH];
    logic [QW-1:0]         q_wr;
    logic [QW-1:0]         q_rd;
    logic [CW-1:0]         occ;

    logic                  req_valid_int;
    logic                  accept;
    logic                  resp_ok;
    logic                  resp_keep;
    logic                  pop;
    logic [SW-1:0]         credit_sum;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_seq;
    logic [ADDR_WIDTH-1:0] pc_redirect;

    // Issue, response classification and decode-side view of the queue head
    always_comb begin
        credit_sum    = SW'(occ) + SW'(outstanding);
        req_valid_int = reset && !branch_taken
                        && (outstanding < OW'(MAX_OUTSTANDING))
                        && (credit_sum < SW'(QUEUE_DEPTH));
        accept        = req_valid_int && mem.grant;
        resp_ok       = mem.data_valid && (outstanding != '0);
        resp_keep     = resp_ok && (discard == '0) && !branch_taken;
        uop_valid_out = (occ != '0) && !branch_taken;
        pop           = uop_valid_out && !system_stall;
        opcode        = uop_valid_out ? q_inst[q_rd] : '0;
        pc_out        = uop_valid_out ? q_pc[q_rd]   : '0;
        pc_inc        = fetch_pc + 1'b1;
        pc_seq        = (pc_inc == ADDR_WIDTH'(MEM_DEPTH)) ? '0 : pc_inc;
        pc_redirect   = (next_pc >= ADDR_WIDTH'(MEM_DEPTH)) ? '0 : next_pc;
    end

    assign mem.req_valid = req_valid_int;
    assign mem.Addr      = fetch_pc;
    assign mem.we        = 1'b0;
    assign system_flush  = branch_taken;

    // Fetch PC, request credit, stale-response discard count and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (mem.data_valid && (outstanding == '0))
                resp_err <= 1'b1;

            if (branch_taken)
                fetch_pc <= pc_redirect;
            else if (accept)
                fetch_pc <= pc_seq;

            if (accept && !resp_ok)
                outstanding <= outstanding + 1'b1;
            else if (!accept && resp_ok)
                outstanding <= outstanding - 1'b1;

            // every request still in flight at redirect time returns stale data
            if (branch_taken)
                discard <= resp_ok ? outstanding - 1'b1 : outstanding;
            else if (resp_ok && (discard != '0))
                discard <= discard - 1'b1;
        end
    end

    // In-flight PC FIFO pointers; depth need not be a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_wr <= '0;
            if_rd <= '0;
        end else if (branch_taken) begin
            if_wr <= '0;
            if_rd <= '0;
        end else begin
            if (accept)
                if_wr <= (if_wr == FW'(MAX_OUTSTANDING - 1)) ? '0 : if_wr + 1'b1;
            if (resp_keep)
                if_rd <= (if_rd == FW'(MAX_OUTSTANDING - 1)) ? '0 : if_rd + 1'b1;
        end
    end

    // In-flight PC storage
    always_ff @(posedge clk) begin
        if (accept)
            inflight[if_wr] <= fetch_pc;
    end

    // Prefetch queue pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_wr <= '0;
            q_rd <= '0;
            occ  <= '0;
        end else if (branch_taken) begin
            q_wr <= '0;
            q_rd <= '0;
            occ  <= '0;
        end else begin
            if (resp_keep)
                q_wr <= q_wr + 1'b1;
            if (pop)
                q_rd <= q_rd + 1'b1;
            if (resp_keep && !pop)
                occ <= occ + 1'b1;
            else if (!resp_keep && pop)
                occ <= occ - 1'b1;
        end
    end

    // Prefetch queue storage, tagged with the PC that produced it
    always_ff @(posedge clk) begin
        if (resp_keep) begin
            q_pc[q_wr]   <= inflight[if_rd];
            q_inst[q_wr] <= mem.rdata;
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - directed vector bench for fetch_queue_unit
`timescale 1ns/1ps
module tb_fetch_queue_unit;
    logic        clk;
    logic        reset;
    logic        system_stall;
    logic        branch_taken;
    logic [31:0] next_pc;
    logic        system_flush;
    logic        uop_valid_out;
    logic [31:0] opcode;
    logic [31:0] pc_out;
    logic        resp_err;

    fetch_queue_unit_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) mem();

    fetch_queue_unit #(
        .ADDR_WIDTH(32), .INST_WIDTH(32), .MEM_DEPTH(16),
        .QUEUE_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'd0)
    ) dut (
        .clk(clk), .reset(reset), .mem(mem),
        .system_stall(system_stall), .branch_taken(branch_taken), .next_pc(next_pc),
        .system_flush(system_flush), .uop_valid_out(uop_valid_out),
        .opcode(opcode), .pc_out(pc_out), .resp_err(resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        g;
        logic        dv;
        logic [31:0] rd;
        logic        st;
        logic        br;
        logic [31:0] npc;
        logic        rv;
        logic [31:0] addr;
        logic        uop;
        logic [31:0] op;
        logic [31:0] pc;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t        tv [18];
    pend_t       pend [$];
    logic [31:0] pops [$];
    logic [31:0] pop_op [$];
    int          pop_cyc [$];
    int          n_vec;
    int          n_bad;
    int          cyc;
    int          lat;
    int          accepts;
    logic        last_rv;
    logic [31:0] last_addr;
    logic        we_bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem.grant      = 1'b0;
        mem.data_valid = 1'b0;
        mem.rdata      = '0;
        system_stall   = 1'b0;
        branch_taken   = 1'b0;
        next_pc        = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pend.delete();
        pops.delete();
        pop_op.delete();
        pop_cyc.delete();
        cyc     = 0;
        accepts = 0;
    endtask

    // one cycle against a fixed-latency in-order memory returning 0x100+addr
    task automatic mstep(input logic st, input logic br, input logic [31:0] npc);
        @(negedge clk);
        system_stall = st;
        branch_taken = br;
        next_pc      = npc;
        mem.grant    = 1'b1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem.data_valid = 1'b1;
            mem.rdata      = 32'h100 + pend[0].addr;
            void'(pend.pop_front());
        end else begin
            mem.data_valid = 1'b0;
            mem.rdata      = '0;
        end
        #1;
        if (mem.we !== 1'b0) we_bad = 1'b1;
        last_rv   = mem.req_valid;
        last_addr = mem.Addr;
        if (mem.req_valid && mem.grant) begin
            pend.push_back('{mem.Addr, cyc + lat});
            accepts++;
        end
        if (uop_valid_out && !system_stall) begin
            pops.push_back(pc_out);
            pop_op.push_back(opcode);
            pop_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        we_bad = 1'b0;
        lat    = 1;
        cyc    = 0;
        reset  = 1'b0;
        idle_inputs();

        //          g  dv rdata     st br npc     rv addr   uop op        pc     err
        tv[0]  = '{1, 0, 32'h0,    0, 0, 32'd0,  1, 32'd0,  0, 32'h0,    32'd0,  0};
        tv[1]  = '{1, 1, 32'h100,  0, 0, 32'd0,  1, 32'd1,  0, 32'h0,    32'd0,  0};
        tv[2]  = '{1, 1, 32'h101,  1, 0, 32'd0,  1, 32'd2,  1, 32'h100,  32'd0,  0};
        tv[3]  = '{1, 1, 32'h102,  1, 0, 32'd0,  1, 32'd3,  1, 32'h100,  32'd0,  0};
        tv[4]  = '{1, 1, 32'h103,  1, 0, 32'd0,  0, 32'd4,  1, 32'h100,  32'd0,  0};
        tv[5]  = '{1, 0, 32'h0,    1, 0, 32'd0,  0, 32'd4,  1, 32'h100,  32'd0,  0};
        tv[6]  = '{1, 0, 32'h0,    0, 0, 32'd0,  0, 32'd4,  1, 32'h100,  32'd0,  0};
        tv[7]  = '{1, 0, 32'h0,    0, 0, 32'd0,  1, 32'd4,  1, 32'h101,  32'd1,  0};
        tv[8]  = '{1, 1, 32'h104,  0, 0, 32'd0,  1, 32'd5,  1, 32'h102,  32'd2,  0};
        tv[9]  = '{1, 0, 32'h0,    0, 0, 32'd0,  1, 32'd6,  1, 32'h103,  32'd3,  0};
        tv[10] = '{1, 1, 32'h105,  0, 1, 32'd10, 0, 32'd7,  0, 32'h0,    32'd0,  0};
        tv[11] = '{1, 1, 32'h106,  0, 0, 32'd0,  1, 32'd10, 0, 32'h0,    32'd0,  0};
        tv[12] = '{1, 1, 32'h10A,  0, 0, 32'd0,  1, 32'd11, 0, 32'h0,    32'd0,  0};
        tv[13] = '{0, 1, 32'h10B,  0, 0, 32'd0,  1, 32'd12, 1, 32'h10A,  32'd10, 0};
        tv[14] = '{0, 0, 32'h0,    0, 1, 32'd20, 0, 32'd12, 0, 32'h0,    32'd0,  0};
        tv[15] = '{0, 0, 32'h0,    0, 0, 32'd0,  1, 32'd0,  0, 32'h0,    32'd0,  0};
        tv[16] = '{0, 1, 32'h55,   0, 0, 32'd0,  1, 32'd0,  0, 32'h0,    32'd0,  0};
        tv[17] = '{0, 0, 32'h0,    0, 0, 32'd0,  1, 32'd0,  0, 32'h0,    32'd0,  1};

        // reset state while reset is held
        #1;
        chk("reset_ctrl", {mem.req_valid, mem.we, uop_valid_out, resp_err}, 4'b0000);
        chk("reset_addr", mem.Addr, 32'd0);
        chk("reset_opcode", opcode, 32'd0);
        chk("reset_pc_out", pc_out, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // cycle-exact vector table starting from a fresh reset
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            mem.grant      = tv[i].g;
            mem.data_valid = tv[i].dv;
            mem.rdata      = tv[i].rd;
            system_stall   = tv[i].st;
            branch_taken   = tv[i].br;
            next_pc        = tv[i].npc;
            #1;
            chk($sformatf("row%0d_ctrl", i),
                {mem.req_valid, mem.we, system_flush, uop_valid_out, resp_err},
                {tv[i].rv, 1'b0, tv[i].br, tv[i].uop, tv[i].err});
            chk($sformatf("row%0d_addr", i), mem.Addr, tv[i].addr);
            chk($sformatf("row%0d_opcode", i), opcode, tv[i].op);
            chk($sformatf("row%0d_pc_out", i), pc_out, tv[i].pc);
        end

        // 1-cycle memory: one instruction per cycle, PC wraps 15 -> 0
        do_reset();
        lat = 1;
        for (int i = 0; i < 40; i++) mstep(1'b0, 1'b0, 32'd0);
        chk("steady_pop_count", pops.size(), 38);
        chk("steady_first_cycle", pop_cyc[0], 2);
        for (int k = 0; k < 38; k++) begin
            chk($sformatf("steady_pc%0d", k), pops[k], 32'(k % 16));
            chk($sformatf("steady_op%0d", k), pop_op[k], 32'h100 + 32'(k % 16));
            chk($sformatf("steady_cyc%0d", k), pop_cyc[k], 2 + k);
        end
        chk("steady_resp_err", resp_err, 1'b0);

        // stall from reset: credits stop issue after QUEUE_DEPTH requests
        do_reset();
        lat = 1;
        for (int i = 0; i < 8; i++) mstep(1'b1, 1'b0, 32'd0);
        chk("stall_accepts", accepts, 4);
        chk("stall_req_low", last_rv, 1'b0);
        chk("stall_no_pop", pops.size(), 0);
        for (int i = 0; i < 10; i++) mstep(1'b0, 1'b0, 32'd0);
        chk("release_pop_count", pops.size(), 10);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("release_pc%0d", k), pops[k], 32'(k));
            chk($sformatf("release_cyc%0d", k), pop_cyc[k], 8 + k);
        end

        // 3-cycle memory: redirect with two requests in flight
        do_reset();
        lat = 3;
        mstep(1'b0, 1'b0, 32'd0);
        mstep(1'b0, 1'b0, 32'd0);
        mstep(1'b0, 1'b1, 32'd9);
        for (int i = 0; i < 14; i++) mstep(1'b0, 1'b0, 32'd0);
        chk("redirect_pop_min", pops.size() >= 3, 1'b1);
        for (int k = 0; k < pops.size(); k++) begin
            chk($sformatf("redirect_pc%0d", k), pops[k], 32'd9 + 32'(k));
            chk($sformatf("redirect_op%0d", k), pop_op[k], 32'h109 + 32'(k));
        end

        // asynchronous reset in the middle of a burst
        do_reset();
        lat = 1;
        for (int i = 0; i < 10; i++) mstep(1'b0, 1'b0, 32'd0);
        chk("pre_reset_uop", uop_valid_out, 1'b1);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_ctrl", {mem.req_valid, mem.we, uop_valid_out, resp_err}, 4'b0000);
        chk("async_addr", mem.Addr, 32'd0);
        chk("async_opcode", opcode, 32'd0);
        chk("async_pc_out", pc_out, 32'd0);
        idle_inputs();
        pend.delete();
        pops.delete();
        pop_op.delete();
        pop_cyc.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        #1;
        chk("restart_req", {mem.req_valid, mem.Addr}, {1'b1, 32'd0});
        for (int i = 0; i < 6; i++) mstep(1'b0, 1'b0, 32'd0);
        chk("restart_first_pc", pops[0], 32'd0);
        chk("restart_first_op", pop_op[0], 32'h100);

        chk("we_never_high", we_bad, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised instruction-fetch front end that replaces the single-request fetch FSM with a pipelined fetcher. It sits between the instruction memory port and decode. It keeps up to MAX_OUTSTANDING in-order read requests in flight and buffers returned instructions, tagged with their PC, in a QUEUE_DEPTH prefetch queue. On branch_taken it redirects and flushes: queued entries are discarded, and responses already in flight are dropped as they return.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC/address width (word-addressed; PC advances by 1 per instruction)
- INST_WIDTH, 32, instruction width
- MEM_DEPTH, 16, instruction memory depth; the PC wraps to 0 when the incremented value equals MEM_DEPTH
- QUEUE_DEPTH, 4, prefetch queue entries; power of 2, at least 2
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; at least 1 and at most QUEUE_DEPTH
- RESET_PC, 0, first fetch address

Ports:
- clk, input, 1, clock; all state updates on the rising edge
- reset, input, 1, asynchronous, active-low reset
- req_valid, output, 1, read request
- Addr, output, ADDR_WIDTH, request address (current fetch PC)
- we, output, 1, write enable; always 0
- grant, input, 1, memory accepts the request this cycle
- data_valid, input, 1, read data returning this cycle; responses arrive in request order
- rdata, input, INST_WIDTH, read data
- system_stall, input, 1, decode cannot accept an instruction this cycle
- branch_taken, input, 1, redirect request
- next_pc, input, ADDR_WIDTH, redirect target
- system_flush, output, 1, equal to branch_taken (combinational)
- uop_valid_out, output, 1, queue head is valid
- opcode, output, INST_WIDTH, queue head instruction; 0 when the queue is empty
- pc_out, output, ADDR_WIDTH, queue head PC; 0 when the queue is empty
- resp_err, output, 1, sticky: data_valid arrived with no request outstanding

## Operation
- Internal state:
  - fetch_pc
  - outstanding count, range 0 to MAX_OUTSTANDING
  - in-flight PC FIFO, depth MAX_OUTSTANDING
  - discard count
  - queue of {pc, inst} with occupancy count
- Issue (combinational): req_valid = !branch_taken && outstanding < MAX_OUTSTANDING && (occupancy + outstanding) < QUEUE_DEPTH.
  - Addr = fetch_pc.
  - The credit rule guarantees that the queue never overflows.
- Accept: on req_valid && grant:
  - push fetch_pc to the in-flight FIFO
  - outstanding++
  - fetch_pc = (fetch_pc+1 == MEM_DEPTH) ? 0 : fetch_pc+1
- Response: on data_valid:
  - If outstanding == 0: set resp_err; no other effect.
  - Else if discard > 0: discard--, outstanding--; no push.
  - Else: pop the in-flight FIFO, push {pc, rdata} to the queue, outstanding--.
- Pop: when uop_valid_out && !system_stall. system_stall blocks only the pop; issue continues until credits run out.
- Accept and response in the same cycle: outstanding remains unchanged. Push and pop in the same cycle: occupancy remains unchanged.
- Flush: when branch_taken is asserted:
  - queue emptied, in-flight FIFO cleared
  - discard = outstanding, less 1 if a response returns this same cycle
  - fetch_pc = next_pc, or 0 if next_pc >= MEM_DEPTH
  - no request issued and no pop
  - uop_valid_out is forced to 0 combinationally
- A later branch_taken during discard applies the same rule: discard is recomputed from outstanding.

## Timing
- Reset (asynchronous, while reset == 0):
  - fetch_pc = RESET_PC
  - all counts 0, queue empty, resp_err 0
  - outputs: req_valid 0, Addr RESET_PC, we 0, uop_valid_out 0, opcode 0, pc_out 0
- First request: req_valid goes high in the first cycle after reset deasserts.
- Assertion of reset mid-operation discards everything immediately. Responses that arrive after reset deasserts with outstanding == 0 set resp_err.
- Request accepted in cycle N: earliest data_valid is N+1. Data is visible on uop_valid_out/opcode/pc_out in the cycle after data_valid (1-cycle response-to-decode latency).
- Steady state with a 1-cycle memory and MAX_OUTSTANDING >= 2: one instruction per cycle.
- Redirect latency: branch_taken in cycle N gives req_valid with Addr = next_pc in N+1, if credits allow.

## Test plan
- Reset with RESET_PC=0 and a 1-cycle grant/data memory returning rdata=0x100+addr -> decode sees pc_out 0,1,2,…,15,0 with opcode 0x100,0x101,…; uop_valid_out stays high in steady state; we is always 0.
- Hold system_stall=1 from reset -> exactly 4 requests are accepted (QUEUE_DEPTH=4), then req_valid=0. Release the stall -> pc_out 0,1,2,3 pop on consecutive cycles and fetching resumes at 4.
- Memory with a 3-cycle response and 2 requests in flight: assert branch_taken with next_pc=9 -> both late responses are dropped, the first uop seen is pc_out=9, and no stale PC appears.
- branch_taken in the same cycle as data_valid with outstanding=2 -> discard=1; exactly one further response is dropped, then pc_out=next_pc.
- branch_taken with next_pc=20 (>= MEM_DEPTH=16) -> the next request has Addr=0. A spurious data_valid with nothing outstanding -> resp_err=1 until reset.
- Assert reset asynchronously mid-burst -> all outputs take their reset values without a clock edge, and fetch restarts at RESET_PC.
